// File: rtl/gpio_ahbl_regs.sv
// gpio_ahbl_regs: AHB-Lite register block in front of the gpio CDC stage.
// Output levels, sticky edge status with W1C, irq enables, registered irq.
module gpio_ahbl_regs #(
  parameter int OUTPUT_IO = 8,
  parameter int INPUT_IO  = 8,
  parameter logic [OUTPUT_IO-1:0] OUT_RESET = '0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 hsel,
  input  logic [31:0]          haddr,
  input  logic [1:0]           htrans,
  input  logic                 hwrite,
  input  logic [2:0]           hsize,
  input  logic [31:0]          hwdata,
  input  logic                 hready,
  output logic                 hreadyout,
  output logic                 hresp,
  output logic [31:0]          hrdata,
  input  logic [INPUT_IO-1:0]  gpio_input_io,
  output logic [INPUT_IO-1:0]  gpio_clear_input_io,
  output logic [OUTPUT_IO-1:0] gpio_output_io,
  output logic                 irq
);

  localparam logic [2:0] A_OUT  = 3'd0;
  localparam logic [2:0] A_IN   = 3'd1;
  localparam logic [2:0] A_RISE = 3'd2;
  localparam logic [2:0] A_FALL = 3'd3;
  localparam logic [2:0] A_EN   = 3'd4;
  localparam logic [2:0] A_SET  = 3'd5;
  localparam logic [2:0] A_CLR  = 3'd6;

  logic                 acc;
  logic                 dp_valid;
  logic                 dp_write;
  logic [2:0]           dp_addr;
  logic                 wr;
  logic                 wr_out;
  logic                 wr_set;
  logic                 wr_clr;
  logic                 wr_en;
  logic [OUTPUT_IO-1:0] wdo;
  logic [INPUT_IO-1:0]  wdi;
  logic [INPUT_IO-1:0]  w1c_r;
  logic [INPUT_IO-1:0]  w1c_f;
  logic [OUTPUT_IO-1:0] out_q;
  logic [OUTPUT_IO-1:0] out_d;
  logic [INPUT_IO-1:0]  prev_q;
  logic [INPUT_IO-1:0]  rise_q;
  logic [INPUT_IO-1:0]  fall_q;
  logic [INPUT_IO-1:0]  en_q;
  logic [INPUT_IO-1:0]  clr_q;
  logic [INPUT_IO-1:0]  rise_evt;
  logic [INPUT_IO-1:0]  fall_evt;
  logic                 irq_q;
  logic [31:0]          rd;
  logic                 unused;

  assign unused = ^{hsize, haddr[31:5], haddr[1:0],
                    htrans[0], hwdata};

  assign hreadyout = 1'b1;
  assign hresp     = 1'b0;

  assign acc    = hsel & hready & htrans[1];
  assign wr     = dp_valid & dp_write;
  assign wr_out = wr & (dp_addr == A_OUT);
  assign wr_set = wr & (dp_addr == A_SET);
  assign wr_clr = wr & (dp_addr == A_CLR);
  assign wr_en  = wr & (dp_addr == A_EN);
  assign wdo    = hwdata[OUTPUT_IO-1:0];
  assign wdi    = hwdata[INPUT_IO-1:0];
  assign w1c_r  = (wr && dp_addr == A_RISE) ? wdi : '0;
  assign w1c_f  = (wr && dp_addr == A_FALL) ? wdi : '0;

  assign rise_evt = gpio_input_io & ~prev_q;
  assign fall_evt = ~gpio_input_io & prev_q;

  assign gpio_output_io      = out_q;
  assign gpio_clear_input_io = clr_q;
  assign irq                 = irq_q;
  assign hrdata              = rd;

  // Capture the address phase for the following data phase.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
    end else if (hready) begin
      dp_valid <= acc;
      dp_write <= hwrite;
      dp_addr  <= haddr[4:2];
    end
  end

  // Next OUT value from plain, set and clear writes.
  always_comb begin
    out_d = out_q;
    unique case (1'b1)
      wr_out:  out_d = wdo;
      wr_set:  out_d = out_q | wdo;
      wr_clr:  out_d = out_q & ~wdo;
      default: out_d = out_q;
    endcase
  end

  // Register state; edge events beat a same-cycle W1C.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_q  <= OUT_RESET;
      prev_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
      en_q   <= '0;
      clr_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      prev_q <= gpio_input_io;
      rise_q <= (rise_q & ~w1c_r) | rise_evt;
      fall_q <= (fall_q & ~w1c_f) | fall_evt;
      if (wr_en) en_q <= wdi;
      clr_q  <= w1c_r | w1c_f;
      irq_q  <= |((rise_q | fall_q) & en_q);
    end
  end

  // Read mux, zero outside a read data phase.
  always_comb begin
    rd = '0;
    if (dp_valid && !dp_write) begin
      case (dp_addr)
        A_OUT:   rd[OUTPUT_IO-1:0] = out_q;
        A_IN:    rd[INPUT_IO-1:0]  = gpio_input_io;
        A_RISE:  rd[INPUT_IO-1:0]  = rise_q;
        A_FALL:  rd[INPUT_IO-1:0]  = fall_q;
        A_EN:    rd[INPUT_IO-1:0]  = en_q;
        default: rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_ahbl_regs.sv
// tb_gpio_ahbl_regs: random and directed bus traffic against a
// register-level model of the gpio AHB-Lite block.
module tb_gpio_ahbl_regs;

  logic        clk = 1'b0;
  logic        resetn;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic [7:0]  gin;
  logic [7:0]  gclr;
  logic [7:0]  gout;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // model state
  logic [7:0]  m_out, m_rise, m_fall, m_en, m_prev, m_clr;
  logic        m_irq;
  logic        pv, pw;
  logic [2:0]  pa;
  logic [31:0] nxt_wd;

  gpio_ahbl_regs #(
    .OUTPUT_IO(8),
    .INPUT_IO(8),
    .OUT_RESET(8'hA5)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .hsel(hsel),
    .haddr(haddr),
    .htrans(htrans),
    .hwrite(hwrite),
    .hsize(hsize),
    .hwdata(hwdata),
    .hready(hready),
    .hreadyout(hreadyout),
    .hresp(hresp),
    .hrdata(hrdata),
    .gpio_input_io(gin),
    .gpio_clear_input_io(gclr),
    .gpio_output_io(gout),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out  = 8'hA5;
    m_rise = '0;
    m_fall = '0;
    m_en   = '0;
    m_prev = '0;
    m_clr  = '0;
    m_irq  = 1'b0;
    pv = 1'b0;
    pw = 1'b0;
    pa = '0;
  endtask

  // One clock edge of the register map, from the bus rules.
  task automatic model_step();
    logic [7:0] rm, fm, wd8;
    if (!resetn) return;
    m_irq = ((m_rise | m_fall) & m_en) != 8'h00;
    rm = '0;
    fm = '0;
    wd8 = hwdata[7:0];
    if (pv && pw) begin
      case (pa)
        3'd0: m_out = wd8;
        3'd2: rm = wd8;
        3'd3: fm = wd8;
        3'd4: m_en = wd8;
        3'd5: m_out = m_out | wd8;
        3'd6: m_out = m_out & ~wd8;
        default: ;
      endcase
    end
    m_rise = (m_rise & ~rm) | (gin & ~m_prev);
    m_fall = (m_fall & ~fm) | (~gin & m_prev);
    m_prev = gin;
    m_clr  = rm | fm;
    pv = hsel & hready & htrans[1];
    pw = hwrite;
    pa = haddr[4:2];
  endtask

  function automatic logic [31:0] exp_rd();
    logic [31:0] r;
    r = '0;
    if (pv && !pw) begin
      case (pa)
        3'd0: r[7:0] = m_out;
        3'd1: r[7:0] = gin;
        3'd2: r[7:0] = m_rise;
        3'd3: r[7:0] = m_fall;
        3'd4: r[7:0] = m_en;
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  // Compare DUT against the model every cycle.
  always @(negedge clk) begin
    chk("gpio_output_io", gout, m_out);
    chk("gpio_clear", gclr, m_clr);
    chk("irq", irq, m_irq);
    chk("hrdata", hrdata, exp_rd());
    chk("hreadyout", hreadyout, 1);
    chk("hresp", hresp, 0);
  end

  task automatic step(input logic s, input logic t,
                      input logic w, input logic [31:0] a,
                      input logic [31:0] wd, input logic hr);
    hsel   = s;
    htrans = t ? 2'b10 : 2'b00;
    hwrite = w;
    haddr  = a;
    hready = hr;
    hsize  = 3'd2;
    hwdata = nxt_wd;
    nxt_wd = (s && t && w && hr) ? wd : $urandom;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d);
    step(1'b1, 1'b1, 1'b1, a, d, 1'b1);
    idle();
  endtask

  task automatic rd(input string nm,
                    input logic [31:0] a,
                    input logic [31:0] exp);
    step(1'b1, 1'b1, 1'b0, a, 32'h0, 1'b1);
    chk(nm, hrdata, exp);
  endtask

  initial begin
    resetn = 1'b0;
    hsel = 0; haddr = 0; htrans = 0; hwrite = 0;
    hsize = 3'd2; hwdata = 0; hready = 1;
    gin = 8'h00;
    nxt_wd = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", gout, 8'hA5);
    chk("rst_irq", irq, 0);
    chk("rst_hreadyout", hreadyout, 1);
    chk("rst_hresp", hresp, 0);
    resetn = 1'b1;
    rd("rd_out_rst", 32'h00, 32'h000000A5);

    // OUT, OUT_SET, OUT_CLR back to back
    step(1, 1, 1, 32'h00, 32'h0F, 1);
    step(1, 1, 1, 32'h14, 32'hF0, 1);
    chk("out_wr", gout, 8'h0F);
    step(1, 1, 1, 32'h18, 32'h03, 1);
    chk("out_set", gout, 8'hFF);
    idle();
    chk("out_clr", gout, 8'hFC);
    rd("rd_set_zero", 32'h14, 32'h0);

    // edge capture
    gin = 8'h01;
    repeat (3) idle();
    rd("rd_in", 32'h04, 32'h01);
    gin = 8'h00;
    repeat (2) idle();
    rd("rd_rise", 32'h08, 32'h01);
    rd("rd_fall", 32'h0C, 32'h01);

    // irq enable and W1C clear pulse
    wr(32'h0C, 32'h01);
    wr(32'h10, 32'h01);
    chk("irq_lat0", irq, 0);
    idle();
    chk("irq_on", irq, 1);
    step(1, 1, 1, 32'h08, 32'h01, 1);
    idle();
    chk("clr_pulse", gclr, 8'h01);
    chk("irq_lat1", irq, 1);
    idle();
    chk("clr_end", gclr, 8'h00);
    chk("irq_off", irq, 0);

    // W1C collides with a new rising edge
    gin = 8'h04;
    idle();
    gin = 8'h00;
    idle();
    step(1, 1, 1, 32'h08, 32'h04, 1);
    gin = 8'h04;
    idle();
    chk("clr_bit2", gclr, 8'h04);
    rd("rise_wins", 32'h08, 32'h04);

    // back-to-back write then read, ignored accesses
    step(1, 1, 1, 32'h10, 32'h55, 1);
    step(1, 1, 0, 32'h10, 32'h0, 1);
    chk("b2b_rd", hrdata, 32'h55);
    wr(32'h1C, 32'hFFFF_FFFF);
    step(1, 0, 0, 32'h10, 32'h0, 1);
    chk("idle_rd", hrdata, 32'h0);
    step(1, 0, 1, 32'h00, 32'h0, 1);
    idle();
    chk("idle_wr", gout, 8'hFC);
    chk("irq_pre_rst", irq, 1);

    // reset in the middle of a read data phase
    step(1, 1, 0, 32'h10, 32'h0, 1);
    chk("rd_pre_rst", hrdata, 32'h55);
    #3;
    resetn = 1'b0;
    model_reset();
    #1;
    chk("arst_out", gout, 8'hA5);
    chk("arst_irq", irq, 0);
    chk("arst_clr", gclr, 8'h00);
    chk("arst_hrdata", hrdata, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic s, t, w, hr;
      logic [31:0] a;
      s  = ($urandom % 4) != 0;
      t  = ($urandom % 4) != 0;
      w  = $urandom % 2;
      hr = pv ? 1'b1 : (($urandom % 5) != 0);
      a  = $urandom;
      gin = gin ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      step(s, t, w, a, $urandom, hr);
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
